// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides; one operation in flight at a time.
// Define ALU_SEQ_MULDIV_EN to build the iterative multiply/divide/remainder datapath.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             div0
);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_seq: WIDTH must be a power of two and at least 4");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_e;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SHL = 4'h3;
  localparam logic [3:0] OP_SHR = 4'h4;
  localparam logic [3:0] OP_SAR = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d, zero_q, zero_d, div0_q, div0_d;
  logic [WIDTH:0]   single_s;

  // Result is {carry, out}; arithmetic runs on WIDTH+1 bits of zero-extended operands.
  function automatic logic [WIDTH:0] single_op(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_SHL:  r = {1'b0, a} << sh;
      OP_SHR:  r = {1'b0, a >> sh};
      OP_SAR:  r = {1'b0, $unsigned($signed(a) >>> sh)};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_NOT:  r = {1'b1, ~a};
      default: r = {(WIDTH + 1){1'b0}};
    endcase
    return r;
  endfunction

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_DIVU = 4'hB;
  localparam logic [3:0] OP_REMU = 4'hC;

  // hi holds the product high half / partial remainder; lo the multiplier / quotient.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             is_iter_s;
  logic [WIDTH:0]   mul_sum_s, div_sh_s, div_diff_s;

  assign is_iter_s  = (op_q == OP_MUL) || (op_q == OP_DIVU) || (op_q == OP_REMU);
  assign mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
  assign div_sh_s   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff_s = div_sh_s - {1'b0, b_q};
`endif

  assign single_s = single_op(op_q, a_q, b_q);

  // Next-state and next-result logic for the IDLE/EXEC/DONE controller.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    div0_d  = div0_q;
`ifdef ALU_SEQ_MULDIV_EN
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = opcode;
          a_d     = in1;
          b_d     = in2;
`ifdef ALU_SEQ_MULDIV_EN
          hi_d    = {WIDTH{1'b0}};
          lo_d    = in1;
          cnt_d   = {SHW{1'b0}};
`endif
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
`ifdef ALU_SEQ_MULDIV_EN
        if (is_iter_s) begin
          cnt_d = cnt_q + SHW'(1);
          if (op_q == OP_MUL) begin
            hi_d = mul_sum_s[WIDTH:1];
            lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
          end else if (!div_diff_s[WIDTH]) begin
            hi_d = div_diff_s[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_sh_s[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == SHW'(WIDTH - 1)) begin
            // Divide-by-zero results are forced so they never depend on iteration detail.
            if (op_q == OP_MUL) begin
              out_d  = lo_d;
              carry_d = |hi_d;
              div0_d = 1'b0;
            end else if (op_q == OP_DIVU) begin
              out_d  = (b_q == {WIDTH{1'b0}}) ? {WIDTH{1'b1}} : lo_d;
              carry_d = 1'b0;
              div0_d = (b_q == {WIDTH{1'b0}});
            end else begin
              out_d  = (b_q == {WIDTH{1'b0}}) ? a_q : hi_d;
              carry_d = 1'b0;
              div0_d = (b_q == {WIDTH{1'b0}});
            end
            zero_d  = (out_d == {WIDTH{1'b0}});
            state_d = DONE;
          end else begin
            state_d = EXEC;
          end
        end else begin
`endif
          out_d   = single_s[WIDTH-1:0];
          carry_d = single_s[WIDTH];
          zero_d  = (single_s[WIDTH-1:0] == {WIDTH{1'b0}});
          div0_d  = 1'b0;
          state_d = DONE;
`ifdef ALU_SEQ_MULDIV_EN
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched operands and registered result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 4'h0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      out_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      div0_q  <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      cnt_q   <= {SHW{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      div0_q  <= div0_d;
`ifdef ALU_SEQ_MULDIV_EN
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH=32), plus reset, handshake and backpressure sequences.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   opcode = 4'h0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         in_ready, out_valid, carry, zero, div0;
  logic [W-1:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_out;
    logic         exp_c;
    logic         exp_d0;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .carry(carry), .zero(zero), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int m;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, " in_ready"}, W'(in_ready), W'(1));
    opcode = v.op; in1 = v.a; in2 = v.b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in1 = '1; in2 = '1;
    m = 1;
    while (!out_valid && m < 100) begin
      @(negedge clk);
      m++;
    end
    chk({nm, " latency"}, W'(m), W'(v.lat));
    chk({nm, " out"}, out, v.exp_out);
    chk({nm, " carry"}, W'(carry), W'(v.exp_c));
    chk({nm, " zero"}, W'(zero), W'(v.exp_out == '0));
    chk({nm, " div0"}, W'(div0), W'(v.exp_d0));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " out_valid drop"}, W'(out_valid), W'(0));
  endtask

  initial begin
    int guard;
    vecs.push_back('{4'h1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 2});
    vecs.push_back('{4'h1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h2, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0, 2});
    vecs.push_back('{4'h3, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 2});
    vecs.push_back('{4'h3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h5, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h4, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h8, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h9, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000, 1'b1, 1'b0, 2});
    vecs.push_back('{4'h0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0, 1'b0, 2});
    vecs.push_back('{4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 2});
`ifdef ALU_SEQ_MULDIV_EN
    vecs.push_back('{4'hA, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0, 33});
    vecs.push_back('{4'hA, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0, 1'b0, 33});
    vecs.push_back('{4'hB, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 1'b0, 33});
    vecs.push_back('{4'hC, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0, 33});
    vecs.push_back('{4'hB, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 33});
    vecs.push_back('{4'hC, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0, 1'b1, 33});
`else
    vecs.push_back('{4'hA, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, 2});
    vecs.push_back('{4'hB, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 2});
    vecs.push_back('{4'hC, 32'h0000_0064, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0, 2});
`endif

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst out_valid", W'(out_valid), W'(0));
    chk("rst in_ready", W'(in_ready), W'(1));
    chk("rst out", out, '0);
    chk("rst carry", W'(carry), W'(0));
    chk("rst zero", W'(zero), W'(0));
    chk("rst div0", W'(div0), W'(0));
    rst_n = 1'b1;

    // Reset in the middle of an operation discards it
    @(negedge clk);
`ifdef ALU_SEQ_MULDIV_EN
    opcode = 4'hA;
`else
    opcode = 4'h1;
`endif
    in1 = 32'd7; in2 = 32'd6; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst async out_valid", W'(out_valid), W'(0));
    chk("midrst async in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", W'(out_valid), W'(0));
    chk("midrst out", out, '0);
    chk("midrst in_ready", W'(in_ready), W'(1));
    repeat (40) @(negedge clk);
    chk("midrst no stale result", W'(out_valid), W'(0));

    // Directed vector table
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d op%h", i, vecs[i].op));

    // Backpressure: result held while out_ready stays low, requests ignored
    @(negedge clk);
    opcode = 4'h1; in1 = 32'h1234_5678; in2 = 32'h1111_1111; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("bp out_valid", W'(out_valid), W'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; opcode = 4'h2; in1 = 32'h0000_0001; in2 = 32'h0000_0009;
      @(negedge clk);
      chk($sformatf("bp out c%0d", i), out, 32'h2345_6789);
      chk($sformatf("bp valid c%0d", i), W'(out_valid), W'(1));
      chk($sformatf("bp in_ready c%0d", i), W'(in_ready), W'(0));
      chk($sformatf("bp carry c%0d", i), W'(carry), W'(0));
    end
    // in_valid during the output handshake cycle is not accepted
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("hs no accept in_ready", W'(in_ready), W'(1));
    chk("hs no accept out_valid", W'(out_valid), W'(0));
    @(negedge clk);
    chk("hs idle stays", W'(out_valid), W'(0));
    run_vec('{4'h2, 32'h0000_0009, 32'h0000_0001, 32'h0000_0008, 1'b0, 1'b0, 2}, "after bp sub");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the combinational ALU.
- Register-in/register-out execution unit with valid/ready handshakes on both sides.
- Adds iterative multiply, unsigned divide and remainder to the existing add/sub/shift/logic set.
- Sits between the decode/operand-fetch stage and writeback; stalls upstream while a multi-cycle op is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; WIDTH >= 4 and a power of two (elaboration-time check).
- SHW, $clog2(WIDTH), shift-amount bits taken from in2[SHW-1:0]; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; equals (state == IDLE).
- opcode  in  4  operation select.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- carry  out  1  carry/borrow/overflow flag.
- zero  out  1  out == 0.
- div0  out  1  divide/remainder by zero occurred.

Behaviour:
- Reset (async, rst_n low): state=IDLE; out=0, carry=0, zero=0, div0=0, out_valid=0. Internal counter and accumulators are cleared. An op in flight is discarded, with no result.
- States and transitions:
  - IDLE -> (in_valid) latch opcode/in1/in2 -> EXEC.
  - EXEC: single-cycle ops finish in one cycle -> DONE.
  - EXEC: mul/div ops run WIDTH iterations -> DONE.
  - DONE: out_valid=1; outputs are held stable until out_ready=1, then -> IDLE.
- Latency, measured from accept edge N:
  - Single-cycle ops: out_valid at edge N+2.
  - Mul/div/rem: out_valid at edge N+WIDTH+1.
- Throughput: one op in flight. in_ready is 0 in EXEC and DONE. A new accept occurs no earlier than the cycle after out handshake.
- Opcodes. All arithmetic is on WIDTH+1 bits with the operands zero-extended; carry = bit WIDTH:
  - 1 add.
  - 2 sub: carry=1 on borrow (in1<in2).
  - 3 shl: carry = last bit shifted out, 0 if shift amount is 0.
  - 4 shr (logical): carry=0.
  - 5 sar (arithmetic): carry=0.
  - 6 and, 7 or, 8 xor: carry=0.
  - 9 not: out=~in1, carry=1.
  - A mul: out = low WIDTH bits of unsigned product; carry=1 iff high WIDTH bits are nonzero. Shift-add, one partial product per cycle.
  - B divu: out = quotient. Restoring division, one bit per cycle.
  - C remu: out = remainder.
  - 0, D-F: out=0, carry=0, zero=1, single-cycle.
- Divide by zero (B/C with in2=0):
  - Still takes WIDTH cycles.
  - divu: out = all-ones. remu: out = in1.
  - div0=1 and carry=0.
- div0 is 0 for every other case and is updated with each result.
- zero is computed from the final out value for all ops.
- out_valid and out_ready both high in the same cycle: transfer completes. in_valid seen in that same cycle is NOT accepted (in_ready=0).
- Operand inputs are sampled only at accept; changes during EXEC have no effect.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined: opcodes A/B/C behave as above, using the iterative datapath.
- Undefined:
  - The iterative datapath and counter are not built.
  - A/B/C are treated as unknown opcodes: single-cycle, out=0, carry=0, zero=1, div0=0.

Test Plan:
1. Reset then idle: rst_n low mid-mul (cycle 5 of 32), then high -> out_valid=0, out=0, in_ready=1 next cycle, no stale result.
2. WIDTH=32, add 0xFFFFFFFF+0x1 -> out=0, carry=1, zero=1, out_valid at edge N+2. sub 3-5 -> out=0xFFFFFFFE, carry=1.
3. Shifts: shl 0x80000001 by 1 -> out=0x00000002, carry=1. sar 0x80000000 by 31 -> 0xFFFFFFFF. shr by in2=0x21 uses 1 -> 0x40000000.
4. mul 0x10000 * 0x10000 -> out=0, carry=1, zero=1. mul 7*6 -> out=42, carry=0. out_valid at edge N+33.
5. divu 100/7 -> 14; remu 100%7 -> 2. divu 5/0 -> 0xFFFFFFFF, div0=1. remu 5/0 -> 5, div0=1.
6. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out/flags stable, in_ready=0, in_valid ignored. Release -> IDLE, next op accepted. Repeat with ALU_SEQ_MULDIV_EN undefined: opcode A returns out=0, zero=1 at N+2.
